// File: rtl/hs_angle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : hs_angle_fetch
// Description : Pulls angles from the host over the next/ack/has-next
//               handshake, buffers them and streams them downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_angle_fetch #(
    parameter int FIFO_DEPTH   = 4,
    parameter int COUNT_LENGTH = 8,
    parameter int ANGLE_LENGTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ANGLE_LENGTH-1:0] hs_angle,
    input  logic                    hs_next_angle_ack,
    input  logic                    hs_has_next_angle,
    output logic                    hs_next_angle,
    output logic [ANGLE_LENGTH-1:0] angle_data,
    output logic                    angle_last,
    output logic                    angle_valid,
    input  logic                    angle_ready,
    output logic [COUNT_LENGTH-1:0] angle_count,
    output logic                    busy,
    output logic                    done
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [c_PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [COUNT_LENGTH-1:0]  angle_count_q, angle_count_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Each entry is {last, angle}
    logic [ANGLE_LENGTH:0]    mem_q [FIFO_DEPTH];

    logic                     w_space;
    logic                     w_req;
    logic                     w_push;
    logic                     w_push_last;
    logic                     w_pop;
    logic                     w_valid;

    always_comb begin
        w_valid     = (fifo_cnt_q != '0);
        // Space is judged on the pre-pop level: no full-FIFO bypass.
        w_space     = (fifo_cnt_q < c_CNT_W'(FIFO_DEPTH));
        w_pop       = w_valid && angle_ready;
        w_req       = (state_q == ST_FETCH) && w_space && hs_has_next_angle;
        w_push_last = (state_q == ST_FETCH) && w_space && !hs_has_next_angle;
        w_push      = w_push_last || (w_req && hs_next_angle_ack);
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        angle_count_d = angle_count_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d      = rd_ptr_q + c_PTR_W'(1);
            angle_count_d = angle_count_q + COUNT_LENGTH'(1);
        end

        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + c_CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - c_CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_FETCH;
                    angle_count_d = '0;
                end
            end
            ST_FETCH: begin
                if (w_push_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && (fifo_cnt_q == c_CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            angle_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            angle_count_q <= angle_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q] <= {w_push_last, hs_angle};
        end
    end

    assign hs_next_angle = w_req;
    assign angle_valid   = w_valid;
    assign angle_data    = w_valid ? mem_q[rd_ptr_q][ANGLE_LENGTH-1:0] : '0;
    assign angle_last    = w_valid ? mem_q[rd_ptr_q][ANGLE_LENGTH] : 1'b0;
    assign angle_count   = angle_count_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_angle_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hs_angle_fetch
// Description : Scoreboard bench for hs_angle_fetch with a simple host model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_angle_fetch;

    localparam int c_DEPTH = 2;
    localparam int c_CL    = 8;
    localparam int c_AL    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [c_AL-1:0]   hs_angle;
    logic              hs_next_angle_ack;
    logic              hs_has_next_angle;
    logic              hs_next_angle;
    logic [c_AL-1:0]   angle_data;
    logic              angle_last;
    logic              angle_valid;
    logic              angle_ready;
    logic [c_CL-1:0]   angle_count;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    hs_angle_fetch #(
        .FIFO_DEPTH   (c_DEPTH),
        .COUNT_LENGTH (c_CL),
        .ANGLE_LENGTH (c_AL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .hs_angle          (hs_angle),
        .hs_next_angle_ack (hs_next_angle_ack),
        .hs_has_next_angle (hs_has_next_angle),
        .hs_next_angle     (hs_next_angle),
        .angle_data        (angle_data),
        .angle_last        (angle_last),
        .angle_valid       (angle_valid),
        .angle_ready       (angle_ready),
        .angle_count       (angle_count),
        .busy              (busy),
        .done              (done)
    );

    // Host angle generator: angles 0, step, 2*step ... below limit.
    logic            host_rst;
    int              host_limit;
    int              host_step;
    int              hold_req;
    int              hold_len;
    logic [c_AL-1:0] host_a;
    int              acked;
    int              hold_used;
    int              req_cycles;
    logic            w_hold;

    assign hs_angle          = host_a;
    assign hs_has_next_angle = (int'(host_a) + host_step) < host_limit;
    assign w_hold            = (acked == hold_req) && (hold_used < hold_len);
    assign hs_next_angle_ack = hs_next_angle && !w_hold;

    always @(posedge clk) begin
        if (host_rst) begin
            host_a     <= '0;
            acked      <= 0;
            hold_used  <= 0;
            req_cycles <= 0;
        end else if (hs_next_angle) begin
            req_cycles <= req_cycles + 1;
            if (hs_next_angle_ack) begin
                host_a <= host_a + c_AL'(host_step);
                acked  <= acked + 1;
            end else begin
                hold_used <= hold_used + 1;
            end
        end
    end

    typedef struct {
        logic [c_AL-1:0] d;
        logic            l;
        logic [c_CL-1:0] c;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_exp(input int d, input bit l, input int c);
        exp_t e;
        e.d = c_AL'(d);
        e.l = l;
        e.c = c_CL'(c);
        q.push_back(e);
    endtask

    task automatic push_sweep4();
        push_exp(0,   1'b0, 0);
        push_exp(45,  1'b0, 1);
        push_exp(90,  1'b0, 2);
        push_exp(135, 1'b1, 3);
    endtask

    // Monitor: every accepted head entry is checked against the scoreboard.
    logic            prev_stall = 1'b0;
    logic [c_AL-1:0] prev_d;
    logic            prev_l;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!angle_valid || angle_data !== prev_d || angle_last !== prev_l) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b d=%0d l=%0b, required v=1 d=%0d l=%0b",
                             angle_valid, angle_data, angle_last, prev_d, prev_l);
                end
            end
            if (angle_valid && angle_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pop: got d=%0d l=%0b, required no output",
                             angle_data, angle_last);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (angle_data !== e.d || angle_last !== e.l || angle_count !== e.c) begin
                        n_err++;
                        $display("FAIL pop: got d=%0d l=%0b cnt=%0d, required d=%0d l=%0b cnt=%0d",
                                 angle_data, angle_last, angle_count, e.d, e.l, e.c);
                    end
                end
            end
            prev_stall <= angle_valid && !angle_ready;
            prev_d     <= angle_data;
            prev_l     <= angle_last;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({name, "_done"}, int'(done), 1);
        cyc(1);
    endtask

    task automatic new_test(input int limit, input int hreq, input int hlen);
        host_limit = limit;
        host_step  = 45;
        hold_req   = hreq;
        hold_len   = hlen;
        reset      = 1'b1;
        host_rst   = 1'b1;
        q.delete();
        cyc(1);
        reset      = 1'b0;
        host_rst   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        host_rst    = 1'b1;
        start       = 1'b0;
        angle_ready = 1'b1;
        host_limit  = 180;
        host_step   = 45;
        hold_req    = -1;
        hold_len    = 0;
        cyc(2);
        @(negedge clk);
        chk("rst_valid", int'(angle_valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_req",   int'(hs_next_angle), 0);
        chk("rst_data",  int'(angle_data), 0);
        chk("rst_last",  int'(angle_last), 0);
        chk("rst_count", int'(angle_count), 0);

        // Basic sweep; a start pulse lands while in FETCH and must be ignored.
        new_test(180, -1, 0);
        angle_ready = 1'b1;
        push_sweep4();
        pulse_start();
        cyc(1);
        pulse_start();
        @(negedge clk);
        chk("t1_busy_after_start", int'(busy), 1);
        wait_done("t1");
        chk("t1_count", int'(angle_count), 4);
        chk("t1_reqs",  req_cycles, 3);
        chk("t1_sb_empty", q.size(), 0);

        // Back-pressure with a two-entry FIFO.
        new_test(180, -1, 0);
        angle_ready = 1'b0;
        push_sweep4();
        pulse_start();
        cyc(19);
        @(negedge clk);
        chk("t2_req_full", int'(hs_next_angle), 0);
        chk("t2_reqs",     req_cycles, 2);
        chk("t2_valid",    int'(angle_valid), 1);
        chk("t2_head",     int'(angle_data), 0);
        chk("t2_host",     int'(host_a), 90);
        cyc(1);
        angle_ready = 1'b1;
        wait_done("t2");
        chk("t2_count", int'(angle_count), 4);
        chk("t2_sb_empty", q.size(), 0);

        // Host withholds ack for three cycles on its second request.
        new_test(180, 1, 3);
        angle_ready = 1'b1;
        push_sweep4();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acked == 1) break;
            cyc(1);
        end
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_held", int'(hs_next_angle), 1);
            chk("t3_no_ack", int'(hs_next_angle_ack), 0);
            chk("t3_valid", int'(angle_valid), (i == 0) ? 1 : 0);
            cyc(1);
            @(negedge clk);
        end
        chk("t3_ack_req", int'(hs_next_angle), 1);
        chk("t3_ack",     int'(hs_next_angle_ack), 1);
        chk("t3_angle",   int'(hs_angle), 45);
        cyc(1);
        wait_done("t3");
        chk("t3_count", int'(angle_count), 4);
        chk("t3_reqs",  req_cycles, 6);
        chk("t3_sb_empty", q.size(), 0);

        // Single-angle sweep: no request, one last entry.
        new_test(1, -1, 0);
        angle_ready = 1'b1;
        push_exp(0, 1'b1, 0);
        pulse_start();
        @(negedge clk);
        chk("t4_no_req", int'(hs_next_angle), 0);
        cyc(1);
        wait_done("t4");
        chk("t4_count", int'(angle_count), 1);
        chk("t4_reqs",  req_cycles, 0);
        chk("t4_sb_empty", q.size(), 0);

        // Reset with two entries buffered, then a fresh sweep.
        new_test(180, -1, 0);
        angle_ready = 1'b0;
        pulse_start();
        cyc(3);
        @(negedge clk);
        chk("t5_pre_valid", int'(angle_valid), 1);
        chk("t5_pre_reqs",  req_cycles, 2);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(angle_valid), 0);
        chk("t5_busy",  int'(busy), 0);
        chk("t5_done",  int'(done), 0);
        chk("t5_count", int'(angle_count), 0);
        chk("t5_req",   int'(hs_next_angle), 0);
        cyc(1);
        host_rst = 1'b1;
        cyc(1);
        host_rst = 1'b0;
        angle_ready = 1'b1;
        push_sweep4();
        pulse_start();
        wait_done("t5");
        chk("t5_sweep_count", int'(angle_count), 4);
        chk("t5_sb_empty", q.size(), 0);

        // start in DONE is ignored.
        pulse_start();
        cyc(2);
        @(negedge clk);
        chk("t6_done",  int'(done), 1);
        chk("t6_busy",  int'(busy), 0);
        chk("t6_count", int'(angle_count), 4);
        chk("t6_valid", int'(angle_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs_angle_fetch.md
Name: hs_angle_fetch

Overview:
- Consumer-side counterpart of the host angle generator. Pulls angles over the hs_next_angle / hs_next_angle_ack / hs_has_next_angle handshake and buffers them in a small FIFO.
- Presents angles to the projection pipeline on a valid/ready stream, with a last flag on the final angle of the sweep.
- Sits between the host angle source and the processing-element dispatch logic.
- Terminates cleanly when the host reports no further angles.

Parameters:
- kFifoDepth, 4, number of buffered angles (power of two, >=2).
- kCountLength, 8, width of the dispatched-angle counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse to begin a sweep; honoured only in IDLE.
- hs_angle  in  `kAngleLength  current angle from host; valid whenever the sweep is active.
- hs_next_angle_ack  in  1  host accepted the advance request this cycle.
- hs_has_next_angle  in  1  host has an angle beyond hs_angle.
- hs_next_angle  out  1  advance request to host; combinational from state and FIFO level.
- angle_data  out  `kAngleLength  head-of-FIFO angle.
- angle_last  out  1  head-of-FIFO angle is the final one of the sweep.
- angle_valid  out  1  FIFO non-empty.
- angle_ready  in  1  downstream accepts the head entry when angle_valid && angle_ready.
- angle_count  out  kCountLength  angles popped since start; wraps modulo 2^kCountLength.
- busy  out  1  state is FETCH or DRAIN.
- done  out  1  state is DONE.

Behaviour:
- Reset (synchronous, active-high) forces the following; reset mid-sweep discards all buffered entries:
  - state = IDLE;
  - FIFO empty;
  - angle_count = 0;
  - hs_next_angle, angle_valid, angle_last, busy and done all 0;
  - angle_data = 0.
- FSM state IDLE: if start, go to FETCH and clear angle_count to 0. Otherwise hold.
- FSM state FETCH. Here space = (fifo count < kFifoDepth), measured before this cycle's pop; there is no full-FIFO bypass.
  - If space && hs_has_next_angle: assert hs_next_angle. When hs_next_angle_ack is 1 the same cycle, push {hs_angle, last=0}. This is the pre-increment value; the host advances next cycle.
  - If space && !hs_has_next_angle: do not assert hs_next_angle. Push {hs_angle, last=1} and go to DRAIN.
  - If no space: hs_next_angle = 0, no push.
  - If hs_next_angle && !hs_next_angle_ack: no push, retry next cycle.
- FSM state DRAIN: no requests or pushes. When the FIFO becomes empty after a pop, go to DONE.
- FSM state DONE: terminal until reset. start is ignored; done = 1.
- start outside IDLE has no effect.
- FIFO:
  - registered storage; a pushed angle is visible on angle_data no earlier than the next cycle (1-cycle fetch-to-valid latency);
  - push and pop in the same cycle leaves the count unchanged;
  - pointers wrap modulo kFifoDepth.
- angle_data and angle_last are stable while angle_valid && !angle_ready.
- angle_count increments on every pop.
- Exactly one last=1 entry is produced per sweep.

Test Plan:
- Host model with limit 180 and step 45; start pulse; angle_ready=1 throughout.
  - Required: angle_data sequence 0, 45, 90, 135, with angle_last=1 only on 135.
  - Required: hs_next_angle asserted exactly 3 times.
  - Required: done=1 after the final pop; angle_count=4.
- Same host, angle_ready=0 for the first 20 cycles, kFifoDepth=2.
  - Required: exactly 2 entries (0, 45) buffered and hs_next_angle held 0 while full.
  - Required: after ready rises, the full sequence completes with no lost or duplicated angles.
- Host withholds ack for 3 cycles on the second request.
  - Required: hs_next_angle stays 1 and no push occurs.
  - Required: 45 is pushed on the ack cycle; the output sequence is unchanged.
- Host with hs_has_next_angle=0 at start (single angle 0).
  - Required: no request issued; one entry {0, last=1}; done after pop; angle_count=1.
- Reset asserted mid-sweep with 2 entries buffered.
  - Required: next cycle angle_valid=0, busy=0, state IDLE, angle_count=0.
  - Required: a subsequent start runs a fresh sweep.
- start pulsed during FETCH and in DONE: no state change, no counter clear.
